// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared widths, RV32I load/store funct3 codes and FSM state type for the
// load/store unit memory controller.
package lsu_mem_ctrl_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_RMW_WR = 1'b1
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Pipeline request/response and data-memory bus of the load/store unit.
// The slave modport is the controller; master is the pipeline plus memory.
interface lsu_mem_ctrl_if;
  import lsu_mem_ctrl_pkg::*;

  logic              req_load;
  logic              req_store;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] load_data;
  logic              stall;
  logic              access_err;
  logic [ADDR_W-1:0] mem_addrs;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_load, req_store, funct3, req_addr, req_wdata, mem_rdata,
    input  load_data, stall, access_err, mem_addrs, mem_data, mem_we, mem_re
  );

  modport slave (
    input  req_load, req_store, funct3, req_addr, req_wdata, mem_rdata,
    output load_data, stall, access_err, mem_addrs, mem_data, mem_we, mem_re
  );

endinterface

// File: rtl/lsu_mem_ctrl_align.sv
// Combinational lane logic: load extract/extend, byte/half store merge into
// the read word, and misalignment / illegal-encoding detection.
module lsu_align
  import lsu_mem_ctrl_pkg::*;
(
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_data_o,
  output logic [DATA_W-1:0] merged_o,
  output logic              err_o
);

  logic [DATA_W-1:0] rshift;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [4:0]        b_sh;
  logic [4:0]        h_sh;
  logic              misalign;
  logic              illegal;

  assign b_sh   = {addr_lo_i, 3'b000};
  assign h_sh   = {addr_lo_i[1], 4'b0000};
  assign rshift = rdata_i >> b_sh;
  assign lane_b = rshift[7:0];
  assign lane_h = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    load_data_o = '0;
    case (funct3_i)
      F3_B:    load_data_o = {{24{lane_b[7]}}, lane_b};
      F3_H:    load_data_o = {{16{lane_h[15]}}, lane_h};
      F3_W:    load_data_o = rdata_i;
      F3_BU:   load_data_o = {24'd0, lane_b};
      F3_HU:   load_data_o = {16'd0, lane_h};
      default: load_data_o = '0;
    endcase
  end

  always_comb begin
    merged_o = rdata_i;
    if (funct3_i == F3_B)
      merged_o = (rdata_i & ~(32'h0000_00FF << b_sh)) | ({24'd0, wdata_i[7:0]} << b_sh);
    else if (funct3_i == F3_H)
      merged_o = (rdata_i & ~(32'h0000_FFFF << h_sh)) | ({16'd0, wdata_i[15:0]} << h_sh);
  end

  // Size comes from funct3[1:0] for both loads and stores (BU/HU share B/H sizes).
  always_comb begin
    misalign = 1'b0;
    if (funct3_i[1:0] == 2'd1) misalign = addr_lo_i[0];
    else if (funct3_i[1:0] == 2'd2) misalign = (addr_lo_i != 2'b00);
  end

  always_comb begin
    illegal = 1'b0;
    if (is_load_i && is_store_i)
      illegal = 1'b1;
    else if (is_load_i)
      illegal = (funct3_i == 3'd3) || (funct3_i == 3'd6) || (funct3_i == 3'd7);
    else if (is_store_i)
      illegal = (funct3_i > F3_W);
  end

  assign err_o = (is_load_i || is_store_i) && (illegal || misalign);

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller: word-wide memory accesses with a
// two-cycle read-modify-write for SB/SH and access error flagging.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  lsu_mem_ctrl_if.slave bus
);

  lsu_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic [DATA_W-1:0] ld_ext;
  logic [DATA_W-1:0] merged;
  logic              err;
  logic              req_any;
  logic              rmw_start;

  lsu_align u_align (
    .is_load_i   (bus.req_load),
    .is_store_i  (bus.req_store),
    .funct3_i    (bus.funct3),
    .addr_lo_i   (bus.req_addr[1:0]),
    .rdata_i     (bus.mem_rdata),
    .wdata_i     (bus.req_wdata),
    .load_data_o (ld_ext),
    .merged_o    (merged),
    .err_o       (err)
  );

  assign req_any   = bus.req_load || bus.req_store;
  assign rmw_start = !rst && (state_q == S_IDLE) && bus.req_store && !err
                     && (bus.funct3 != F3_W);

  always_comb begin
    bus.load_data  = '0;
    bus.stall      = 1'b0;
    bus.access_err = 1'b0;
    bus.mem_addrs  = '0;
    bus.mem_data   = '0;
    bus.mem_we     = 1'b0;
    bus.mem_re     = 1'b0;
    if (!rst) begin
      if (state_q == S_RMW_WR) begin
        bus.mem_we    = 1'b1;
        bus.mem_addrs = addr_q;
        bus.mem_data  = data_q;
      end else if (req_any) begin
        if (err) begin
          bus.access_err = 1'b1;
        end else if (bus.req_load) begin
          bus.mem_re    = 1'b1;
          bus.mem_addrs = bus.req_addr;
          bus.load_data = ld_ext;
        end else if (bus.funct3 == F3_W) begin
          bus.mem_we    = 1'b1;
          bus.mem_addrs = bus.req_addr;
          bus.mem_data  = bus.req_wdata;
        end else begin
          bus.mem_re    = 1'b1;
          bus.mem_addrs = bus.req_addr;
          bus.stall     = 1'b1;
        end
      end
    end
  end

  // Requests seen while in S_RMW_WR are ignored; the held copy drives the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rmw_start) begin
            addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            data_q  <= merged;
            state_q <= S_RMW_WR;
          end
        end
        S_RMW_WR: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench: lsu_mem_ctrl against a 64-word memory model, with a
// scoreboard copy of memory and a behavioural load/store reference.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [64];
  logic [31:0] sb  [64];

  assign bus.mem_rdata = bus.mem_re ? mem[bus.mem_addrs[7:2]] : 32'd0;
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addrs[7:2]] <= bus.mem_data;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_err(input bit ld, input bit st, input logic [2:0] f3,
                                 input logic [31:0] a);
    int sz;
    if (ld && st) return 1'b1;
    if (ld && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
    if (st && f3 > 2) return 1'b1;
    sz = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    return (a % sz) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = sb[a[7:2]];
    b = 8'((w >> (8 * (a % 4))) & 32'hFF);
    h = 16'((w >> (16 * ((a % 4) / 2))) & 32'hFFFF);
    case (f3)
      3'd0: return 32'($signed(b));
      3'd1: return 32'($signed(h));
      3'd2: return w;
      3'd4: return {24'd0, b};
      3'd5: return {16'd0, h};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_store(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] wd);
    logic [31:0] w;
    int sh;
    w = sb[a[7:2]];
    if (f3 == 0) begin
      sh = 8 * (a % 4);
      return (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end
    if (f3 == 1) begin
      sh = 16 * ((a % 4) / 2);
      return (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  task automatic idle_inputs();
    bus.req_load  = 1'b0;
    bus.req_store = 1'b0;
    bus.funct3    = 3'd0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
  endtask

  // One pipeline operation; ld_obs returns load_data as seen in the request cycle.
  task automatic op(input bit ld, input bit st, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    output logic [31:0] ld_obs, output logic [31:0] wr_obs);
    bit          e;
    logic [31:0] nw;
    @(negedge clk);
    bus.req_load = ld; bus.req_store = st; bus.funct3 = f3;
    bus.req_addr = a;  bus.req_wdata = wd;
    #1;
    e = ref_err(ld, st, f3, a);
    nw = ref_store(f3, a, wd);
    ld_obs = bus.load_data;
    wr_obs = bus.mem_data;
    chk("access_err", {31'd0, bus.access_err}, {31'd0, e});
    if (e) begin
      chk("err_re", {31'd0, bus.mem_re}, 32'd0);
      chk("err_we", {31'd0, bus.mem_we}, 32'd0);
      chk("err_stall", {31'd0, bus.stall}, 32'd0);
      chk("err_load_data", bus.load_data, 32'd0);
    end else if (ld) begin
      chk("ld_re", {31'd0, bus.mem_re}, 32'd1);
      chk("ld_we", {31'd0, bus.mem_we}, 32'd0);
      chk("ld_stall", {31'd0, bus.stall}, 32'd0);
      chk("ld_addr", bus.mem_addrs, a);
      chk("ld_data", bus.load_data, ref_load(f3, a));
    end else if (f3 == 3'd2) begin
      chk("sw_we", {31'd0, bus.mem_we}, 32'd1);
      chk("sw_re", {31'd0, bus.mem_re}, 32'd0);
      chk("sw_stall", {31'd0, bus.stall}, 32'd0);
      chk("sw_addr", bus.mem_addrs, a);
      chk("sw_data", bus.mem_data, wd);
    end else begin
      chk("rmw1_stall", {31'd0, bus.stall}, 32'd1);
      chk("rmw1_re", {31'd0, bus.mem_re}, 32'd1);
      chk("rmw1_we", {31'd0, bus.mem_we}, 32'd0);
    end
    @(posedge clk); #1;
    if (!e && st && f3 != 3'd2) begin
      @(negedge clk); #1;
      wr_obs = bus.mem_data;
      chk("rmw2_we", {31'd0, bus.mem_we}, 32'd1);
      chk("rmw2_re", {31'd0, bus.mem_re}, 32'd0);
      chk("rmw2_stall", {31'd0, bus.stall}, 32'd0);
      chk("rmw2_addr", bus.mem_addrs, a & 32'hFFFF_FFFC);
      chk("rmw2_data", bus.mem_data, nw);
      @(posedge clk); #1;
    end
    if (!e && st) sb[a[7:2]] = nw;
    idle_inputs();
  endtask

  logic [31:0] lo, wo;

  initial begin
    bit          ld, st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          k;
    for (int i = 0; i < 64; i++) begin mem[i] = 32'd0; sb[i] = 32'd0; end
    idle_inputs();

    // Reset: a pending SW must not write and every output stays low.
    bus.req_store = 1'b1; bus.funct3 = 3'd2; bus.req_addr = 32'h40; bus.req_wdata = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_re", {31'd0, bus.mem_re}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_err", {31'd0, bus.access_err}, 32'd0);
    chk("rst_addr", bus.mem_addrs, 32'd0);
    chk("rst_data", bus.mem_data, 32'd0);
    @(posedge clk); #1;
    chk("rst_mem", mem[16], 32'd0);
    rst = 1'b0;
    idle_inputs();
    @(negedge clk); #1;
    chk("idle_we", {31'd0, bus.mem_we}, 32'd0);
    chk("idle_stall", {31'd0, bus.stall}, 32'd0);

    // Load extension from word 0x10.
    op(0, 1, 3'd2, 32'h10, 32'h8000_FF7F, lo, wo);
    op(1, 0, 3'd0, 32'h10, 0, lo, wo); chk("lb_10", lo, 32'h0000_007F);
    op(1, 0, 3'd0, 32'h11, 0, lo, wo); chk("lb_11", lo, 32'hFFFF_FFFF);
    op(1, 0, 3'd4, 32'h11, 0, lo, wo); chk("lbu_11", lo, 32'h0000_00FF);
    op(1, 0, 3'd1, 32'h12, 0, lo, wo); chk("lh_12", lo, 32'hFFFF_8000);
    op(1, 0, 3'd5, 32'h12, 0, lo, wo); chk("lhu_12", lo, 32'h0000_8000);

    // SW then LW, SB read-modify-write, then LW of the merged word.
    op(0, 1, 3'd2, 32'h20, 32'h1234_5678, lo, wo);
    op(1, 0, 3'd2, 32'h20, 0, lo, wo); chk("lw_20", lo, 32'h1234_5678);
    op(0, 1, 3'd0, 32'h23, 32'h0000_00AB, lo, wo); chk("sb_merge", wo, 32'hAB34_5678);
    op(1, 0, 3'd2, 32'h20, 0, lo, wo); chk("lw_20_merged", lo, 32'hAB34_5678);

    // Misaligned and illegal accesses leave memory untouched.
    op(1, 0, 3'd2, 32'h22, 0, lo, wo);
    op(0, 1, 3'd1, 32'h21, 32'h0000_5555, lo, wo);
    op(1, 0, 3'd3, 32'h20, 0, lo, wo);
    op(1, 1, 3'd2, 32'h20, 32'h0, lo, wo);
    op(1, 0, 3'd2, 32'h20, 0, lo, wo); chk("lw_20_unchanged", lo, 32'hAB34_5678);

    // Reset during the RMW write cycle drops the store.
    op(0, 1, 3'd2, 32'h30, 32'h1111_2222, lo, wo);
    @(negedge clk);
    bus.req_store = 1'b1; bus.funct3 = 3'd1; bus.req_addr = 32'h30; bus.req_wdata = 32'h0000_BEEF;
    #1 chk("rstrmw_stall1", {31'd0, bus.stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    #1;
    chk("rstrmw_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rstrmw_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    @(negedge clk); #1;
    chk("rstrmw_idle_stall", {31'd0, bus.stall}, 32'd0);
    chk("rstrmw_mem", mem[12], 32'h1111_2222);
    op(1, 0, 3'd2, 32'h30, 0, lo, wo); chk("rstrmw_lw", lo, 32'h1111_2222);

    // Randomized mixed stream against the scoreboard.
    for (int n = 0; n < 2000; n++) begin
      k  = $urandom_range(0, 19);
      ld = (k < 10) || (k == 19);
      st = (k >= 10);
      if (ld && !st) begin
        case ($urandom_range(0, 5))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; 4: f3 = 3'd5;
          default: f3 = 3'($urandom_range(0, 7));
        endcase
      end else begin
        f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      end
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1) a = a & 32'hFE;
        else if (f3[1:0] == 2'd2) a = a & 32'hFC;
      end
      op(ld, st, f3, a, $urandom, lo, wo);
    end

    for (int i = 0; i < 64; i++) chk("final_mem", mem[i], sb[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
